// File: rtl/program_loader_ctrl.sv
// rtl/program_loader_ctrl.sv - load/run sequencer between UART RX and the brainfuck core
//
// Purpose: while loading_i is high, bytes arriving on rxData_i/rxValid_i are
// written to code memory at consecutive addresses. When FILTER is set, bytes
// that are not brainfuck commands are dropped. The last memory slot is kept
// free for the 0x00 terminator. After the load the core is held in reset for
// PROC_RESET_CYCLES cycles, then released until procDone_i.
//
// Ports:
//   clk_i        system clock, rising edge
//   reset_i      asynchronous active-high reset
//   loading_i    host download in progress (level)
//   rxData_i     received byte
//   rxValid_i    one-cycle strobe qualifying rxData_i
//   memAddr_o    code memory write address
//   memData_o    code memory write data
//   memWe_o      code memory write enable (single-cycle pulses)
//   procHold_o   reset/hold to the processor core
//   procDone_i   processor reached end of program
//   progLen_o    command bytes stored by the last load
//   overflow_o   sticky: a byte was dropped because memory was full
//   finished_o   program has completed
module program_loader_ctrl #(
    parameter int CODE_ADDR_W       = 4,
    parameter bit FILTER            = 1'b1,
    parameter int PROC_RESET_CYCLES = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   loading_i,
    input  logic [7:0]             rxData_i,
    input  logic                   rxValid_i,
    output logic [CODE_ADDR_W-1:0] memAddr_o,
    output logic [7:0]             memData_o,
    output logic                   memWe_o,
    output logic                   procHold_o,
    input  logic                   procDone_i,
    output logic [CODE_ADDR_W-1:0] progLen_o,
    output logic                   overflow_o,
    output logic                   finished_o
);
    localparam logic [CODE_ADDR_W-1:0] LAST_ADDR = '1;
    localparam int                     CNT_W     = $clog2(PROC_RESET_CYCLES + 1);
    localparam logic [CNT_W-1:0]       CNT_LAST  = CNT_W'(PROC_RESET_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_TERMINATE,
        S_RELEASE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [CODE_ADDR_W-1:0] ptr_q, ptr_d;
    logic [CODE_ADDR_W-1:0] memAddr_q, memAddr_d;
    logic [CODE_ADDR_W-1:0] progLen_q, progLen_d;
    logic [7:0]             memData_q, memData_d;
    logic                   memWe_q, memWe_d;
    logic                   procHold_q, procHold_d;
    logic                   overflow_q, overflow_d;
    logic                   finished_q, finished_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   is_cmd;
    logic                   passes;

    always_comb begin
        case (rxData_i)
            8'h2B, 8'h2D, 8'h3C, 8'h3E,
            8'h5B, 8'h5D, 8'h2E, 8'h2C: is_cmd = 1'b1;
            default:                    is_cmd = 1'b0;
        endcase
    end

    assign passes = !FILTER || is_cmd;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        memAddr_d  = memAddr_q;
        memData_d  = memData_q;
        memWe_d    = 1'b0;
        progLen_d  = progLen_q;
        overflow_d = overflow_q;
        cnt_d      = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (loading_i) begin
                    state_d    = S_LOAD;
                    ptr_d      = '0;
                    overflow_d = 1'b0;
                end
            end
            S_LOAD: begin
                // A strobe in the cycle loading falls is still taken, so its
                // write lands before the terminator written from TERMINATE.
                if (rxValid_i && passes) begin
                    if (ptr_q != LAST_ADDR) begin
                        memWe_d   = 1'b1;
                        memAddr_d = ptr_q;
                        memData_d = rxData_i;
                        ptr_d     = ptr_q + CODE_ADDR_W'(1);
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                if (!loading_i) begin
                    state_d = S_TERMINATE;
                end
            end
            S_TERMINATE: begin
                memWe_d   = 1'b1;
                memAddr_d = ptr_q;
                memData_d = 8'h00;
                progLen_d = ptr_q;
                cnt_d     = '0;
                state_d   = S_RELEASE;
            end
            S_RELEASE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RUN, S_DONE: begin
                // A new download wins over a simultaneous procDone.
                if (loading_i) begin
                    state_d    = S_LOAD;
                    ptr_d      = '0;
                    overflow_d = 1'b0;
                end else if (procDone_i) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered outputs are derived from the upcoming state so they
        // change together with it.
        procHold_d = !(state_d == S_RUN || state_d == S_DONE);
        finished_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            memAddr_q  <= '0;
            memData_q  <= 8'h00;
            memWe_q    <= 1'b0;
            progLen_q  <= '0;
            overflow_q <= 1'b0;
            cnt_q      <= '0;
            procHold_q <= 1'b1;
            finished_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            memAddr_q  <= memAddr_d;
            memData_q  <= memData_d;
            memWe_q    <= memWe_d;
            progLen_q  <= progLen_d;
            overflow_q <= overflow_d;
            cnt_q      <= cnt_d;
            procHold_q <= procHold_d;
            finished_q <= finished_d;
        end
    end

    assign memAddr_o  = memAddr_q;
    assign memData_o  = memData_q;
    assign memWe_o    = memWe_q;
    assign procHold_o = procHold_q;
    assign progLen_o  = progLen_q;
    assign overflow_o = overflow_q;
    assign finished_o = finished_q;
endmodule
